// File: rtl/spi_send_receive.sv
// -----------------------------------------------------------------------------
// spi_send_receive
//
// Single-byte SPI master, mode 0 (sclk idles low), sclk = clk/2.
// A request seen while idle loads the TX byte and starts a transfer of exactly
// 8 sclk pulses. On each sclk rise the master samples miso. On each sclk fall
// it advances the bit count and presents the next mosi bit. The received byte
// appears on dout with data_valid held high until the next accepted request.
//
// Ports
//   clk          system clock, rising-edge active
//   nreset       asynchronous active-low reset
//   send_request start a transfer (ignored while busy)
//   din[7:0]     byte to transmit, captured on acceptance
//   cs_at_end    1: release cs when the transfer ends, 0: keep cs low
//   miso         serial data from the slave
//   mosi         serial data to the slave, MSB first
//   sclk         SPI clock
//   cs           active-low chip select
//   dout[7:0]    last received byte
//   data_valid   dout holds a completed byte
//   processing   transfer in progress
//   bit_counter  bits completed in the current or last transfer (0..8)
// -----------------------------------------------------------------------------
module spi_send_receive (
    input  logic       clk,
    input  logic       nreset,
    input  logic       send_request,
    input  logic [7:0] din,
    input  logic       cs_at_end,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic       cs,
    output logic [7:0] dout,
    output logic       data_valid,
    output logic       processing,
    output logic [3:0] bit_counter
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_q, cs_d;
    logic [7:0]  dout_q, dout_d;
    logic        data_valid_q, data_valid_d;
    logic [3:0]  bit_counter_q, bit_counter_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [3:0]  count_inc_s;

    // Bit count after the fall phase that is about to happen.
    always_comb begin
        count_inc_s = bit_counter_q + 4'd1;
    end

    // Next-state and output logic. While busy, the level of sclk selects the
    // phase: sclk low means the coming edge is a rise, sclk high a fall.
    always_comb begin
        state_d       = state_q;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        cs_d          = cs_q;
        dout_d        = dout_q;
        data_valid_d  = data_valid_q;
        bit_counter_d = bit_counter_q;
        tx_d          = tx_q;
        rx_d          = rx_q;

        case (state_q)
            ST_IDLE: begin
                if (send_request) begin
                    state_d       = ST_BUSY;
                    tx_d          = din;
                    rx_d          = 8'h00;
                    cs_d          = 1'b0;
                    data_valid_d  = 1'b0;
                    bit_counter_d = 4'd0;
                    mosi_d        = din[7];
                    sclk_d        = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!sclk_q) begin
                    // Rise phase: sample miso into the RX LSB.
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso};
                end else begin
                    // Fall phase: count the bit, then either present the next
                    // TX bit or close the transfer.
                    sclk_d        = 1'b0;
                    bit_counter_d = count_inc_s;
                    if (count_inc_s == 4'd8) begin
                        state_d      = ST_IDLE;
                        data_valid_d = 1'b1;
                        dout_d       = rx_q;
                        mosi_d       = 1'b0;
                        cs_d         = cs_at_end ? 1'b1 : 1'b0;
                    end else begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset to the idle, deselected state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            cs_q          <= 1'b1;
            dout_q        <= 8'h00;
            data_valid_q  <= 1'b0;
            bit_counter_q <= 4'd0;
            tx_q          <= 8'h00;
            rx_q          <= 8'h00;
        end else begin
            state_q       <= state_d;
            sclk_q        <= sclk_d;
            mosi_q        <= mosi_d;
            cs_q          <= cs_d;
            dout_q        <= dout_d;
            data_valid_q  <= data_valid_d;
            bit_counter_q <= bit_counter_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
        end
    end

    assign processing  = (state_q == ST_BUSY);
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign cs          = cs_q;
    assign dout        = dout_q;
    assign data_valid  = data_valid_q;
    assign bit_counter = bit_counter_q;

endmodule

// File: tb/tb_spi_send_receive.sv
// -----------------------------------------------------------------------------
// tb_spi_send_receive
//
// Self-checking bench for spi_send_receive. A behavioural slave shifts a chosen
// byte out on miso (changing it only after sclk falls) and collects mosi on
// each sclk rise. Every transfer is judged by what a whole byte exchange must
// look like: the slave's byte comes back on dout, the master's byte is seen
// by the slave, exactly 8 sclk pulses occur, and data_valid rises 16 clocks
// after acceptance.
// -----------------------------------------------------------------------------
module tb_spi_send_receive;

    logic       clk;
    logic       nreset;
    logic       send_request;
    logic [7:0] din;
    logic       cs_at_end;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic       cs;
    logic [7:0] dout;
    logic       data_valid;
    logic       processing;
    logic [3:0] bit_counter;

    int checks;
    int failures;

    spi_send_receive dut (
        .clk          (clk),
        .nreset       (nreset),
        .send_request (send_request),
        .din          (din),
        .cs_at_end    (cs_at_end),
        .miso         (miso),
        .mosi         (mosi),
        .sclk         (sclk),
        .cs           (cs),
        .dout         (dout),
        .data_valid   (data_valid),
        .processing   (processing),
        .bit_counter  (bit_counter)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer. Entered and left at a falling clk edge.
    //   d          byte the master sends
    //   s          byte the slave returns on miso
    //   cae        cs_at_end for this transfer
    //   hold       keep send_request high throughout
    //   pulse_mask bit k set: assert send_request for edge Ek (busy, ignored)
    //   din_chg_k  edge index before which din is scrambled (0 = never)
    task automatic run_xfer(input logic [7:0] d, input logic [7:0] s, input logic cae,
                            input logic hold, input logic [16:0] pulse_mask, input int din_chg_k);
        logic [7:0] seen;
        int         rises;
        int         mbit;
        logic       prev_sclk;
        logic       prev_mosi;
        logic [3:0] prev_bc;
        bit         bad_dv, bad_proc, bad_cs, bad_bc, bad_mosi;

        seen = 8'h00; rises = 0; mbit = 7;
        bad_dv = 1'b0; bad_proc = 1'b0; bad_cs = 1'b0; bad_bc = 1'b0; bad_mosi = 1'b0;

        send_request = 1'b1;
        din          = d;
        cs_at_end    = cae;
        miso         = s[7];
        @(posedge clk);               // E0: acceptance
        @(negedge clk);
        chk("acc_proc", 32'(processing), 32'd1);
        chk("acc_cs",   32'(cs),         32'd0);
        chk("acc_dv",   32'(data_valid), 32'd0);
        chk("acc_bc",   32'(bit_counter), 32'd0);
        chk("acc_mosi", 32'(mosi),       32'(d[7]));
        chk("acc_sclk", 32'(sclk),       32'd0);
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_bc   = bit_counter;

        for (int k = 1; k <= 16; k++) begin
            send_request = hold | pulse_mask[k];
            if (k == din_chg_k) din = 8'($urandom);
            @(posedge clk);           // Ek
            @(negedge clk);
            if (sclk && !prev_sclk) begin
                rises = rises + 1;
                seen  = {seen[6:0], mosi};
            end
            if (!sclk && prev_sclk && mbit > 0) begin
                mbit = mbit - 1;
                miso = s[mbit];
            end
            if (sclk && (mosi !== prev_mosi)) bad_mosi = 1'b1;
            if (bit_counter < prev_bc) bad_bc = 1'b1;
            if (k < 16) begin
                if (data_valid !== 1'b0) bad_dv   = 1'b1;
                if (processing !== 1'b1) bad_proc = 1'b1;
                if (cs !== 1'b0)         bad_cs   = 1'b1;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            prev_bc   = bit_counter;
        end

        chk("end_dv",       32'(data_valid),  32'd1);
        chk("end_dout",     32'(dout),        32'(s));
        chk("end_proc",     32'(processing),  32'd0);
        chk("end_bc",       32'(bit_counter), 32'd8);
        chk("end_cs",       32'(cs),          32'(cae));
        chk("end_mosi",     32'(mosi),        32'd0);
        chk("end_sclk",     32'(sclk),        32'd0);
        chk("sclk_pulses",  32'(rises),       32'd8);
        chk("mosi_byte",    32'(seen),        32'(d));
        chk("dv_early",     32'(bad_dv),      32'd0);
        chk("proc_drop",    32'(bad_proc),    32'd0);
        chk("cs_mid",       32'(bad_cs),      32'd0);
        chk("bc_monotonic", 32'(bad_bc),      32'd0);
        chk("mosi_sclk_hi", 32'(bad_mosi),    32'd0);
    endtask

    // Outputs that reset must force.
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sclk"}, 32'(sclk),        32'd0);
        chk({tag, "_mosi"}, 32'(mosi),        32'd0);
        chk({tag, "_cs"},   32'(cs),          32'd1);
        chk({tag, "_proc"}, 32'(processing),  32'd0);
        chk({tag, "_dv"},   32'(data_valid),  32'd0);
        chk({tag, "_dout"}, 32'(dout),        32'd0);
        chk({tag, "_bc"},   32'(bit_counter), 32'd0);
    endtask

    // Main stimulus sequence.
    initial begin
        logic [7:0] last_dout;
        checks       = 0;
        failures     = 0;
        nreset       = 1'b0;
        send_request = 1'b0;
        din          = 8'h00;
        cs_at_end    = 1'b1;
        miso         = 1'b0;

        #12;
        chk_reset_vals("por");
        @(negedge clk);
        nreset = 1'b1;

        // Basic transfer.
        run_xfer(8'h03, 8'hA5, 1'b1, 1'b0, 17'h0, 0);

        // Idle: outputs hold.
        send_request = 1'b0;
        last_dout = dout;
        repeat (3) @(negedge clk);
        chk("idle_dout", 32'(dout),        32'(last_dout));
        chk("idle_bc",   32'(bit_counter), 32'd8);
        chk("idle_dv",   32'(data_valid),  32'd1);
        chk("idle_proc", 32'(processing),  32'd0);

        // Held request: back-to-back with a one-cycle gap.
        for (int i = 0; i < 3; i++) run_xfer(8'h00, 8'hFF, 1'b1, 1'b1, 17'h0, 0);
        send_request = 1'b0;
        @(negedge clk);
        chk("held_stop", 32'(processing), 32'd0);

        // Chip-select continuity across three transfers.
        chk("cs_before", 32'(cs), 32'd1);
        run_xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0, 17'h0, 0);
        run_xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0, 17'h0, 0);
        run_xfer(8'($urandom), 8'($urandom), 1'b1, 1'b0, 17'h0, 0);
        send_request = 1'b0;

        // Requests while busy at E3 and E9 are ignored.
        run_xfer(8'($urandom), 8'($urandom), 1'b1, 1'b0, 17'h00208, 0);
        send_request = 1'b0;
        @(negedge clk);
        chk("busy_req_ignored", 32'(processing), 32'd0);

        // din scrambled at E2.
        run_xfer(8'hC3, 8'($urandom), 1'b1, 1'b0, 17'h0, 2);
        send_request = 1'b0;

        // Reset mid-transfer around E7.
        @(negedge clk);
        send_request = 1'b1;
        din          = 8'h5A;
        miso         = 1'b1;
        @(posedge clk);
        send_request = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (2) @(posedge clk);
        #1;
        chk("abort_dv_low", 32'(data_valid), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        run_xfer(8'($urandom), 8'($urandom), 1'b1, 1'b0, 17'h0, 0);
        send_request = 1'b0;

        // Randomised transfers with random idle gaps and busy requests.
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            send_request = 1'b0;
            repeat (gap) @(negedge clk);
            run_xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'b0,
                     17'($urandom) & 17'h1FFFE, int'($urandom_range(0, 16)));
        end
        send_request = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
